// File: rtl/core_pkg.sv
// Shared types and constants for the core sequencer: FSM states, RV32 opcodes
// and instruction field positions.
package core_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned FUNCT7_W = 7;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned FUNCT7_LSB = 25;

    localparam logic [OPCODE_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_SYS = 7'b1110011;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic [FUNCT7_W-1:0] funct7;
        logic [REG_W-1:0]    rs2;
        logic [REG_W-1:0]    rs1;
        logic [FUNCT3_W-1:0] funct3;
        logic [REG_W-1:0]    rd;
        logic [OPCODE_W-1:0] opcode;
    } instr_fields_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational RV32 field extraction from the instruction register.
module instr_decode
    import core_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output instr_fields_t      fields
);

    always_comb begin
        fields.opcode = ir[OPCODE_LSB +: OPCODE_W];
        fields.rd     = ir[RD_LSB     +: REG_W];
        fields.funct3 = ir[FUNCT3_LSB +: FUNCT3_W];
        fields.rs1    = ir[RS1_LSB    +: REG_W];
        fields.rs2    = ir[RS2_LSB    +: REG_W];
        fields.funct7 = ir[FUNCT7_LSB +: FUNCT7_W];
    end

endmodule

// File: rtl/core_seq_ctrl.sv
// Fetch/decode/execute/writeback sequencer with ALU timeout and sticky halt.
// Optional retired-instruction counter port oInstrCnt when SEQ_INSTR_CNT_EN is defined.
module core_seq_ctrl
    import core_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] PC_RESET    = WIDTH'(32'h0000_0000),
    parameter int unsigned      ALU_TIMEOUT = 255
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEn,
    output logic                oImemReq,
    output logic [WIDTH-1:0]    oImemAddr,
    input  logic                iImemValid,
    input  logic [INSTR_W-1:0]  iImemData,
    output logic [REG_W-1:0]    oRs1,
    output logic [REG_W-1:0]    oRs2,
    output logic [REG_W-1:0]    oRd,
    output logic [FUNCT3_W-1:0] oFunct3,
    output logic [FUNCT7_W-1:0] oFunct7,
    output logic [OPCODE_W-1:0] oOpcode,
    output logic                oRfRdEn,
    output logic                oAluStart,
    input  logic                iAluDone,
    output logic                oRfWe,
    output logic                oIllegal,
    output logic                oTimeout,
    output logic                oHalt
`ifdef SEQ_INSTR_CNT_EN
    ,
    output logic [31:0]         oInstrCnt
`endif
);

    localparam int unsigned           TMO_W    = $clog2(ALU_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(ALU_TIMEOUT - 1);
    localparam logic [WIDTH-1:0]      PC_STEP  = WIDTH'(4);

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     pc;
    logic [WIDTH-1:0]     pc_nxt;
    logic [INSTR_W-1:0]   ir;
    logic [INSTR_W-1:0]   ir_nxt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [TMO_W-1:0]     tmo_cnt_nxt;
    instr_fields_t        fields;

    logic                 imem_req_nxt;
    logic                 rf_rd_en_nxt;
    logic                 alu_start_nxt;
    logic                 rf_we_nxt;
    logic                 illegal_nxt;
    logic                 timeout_nxt;
    logic                 halt_nxt;

    instr_decode u_decode (
        .ir     (ir),
        .fields (fields)
    );

    assign oImemAddr = pc;
    assign oRs1      = fields.rs1;
    assign oRs2      = fields.rs2;
    assign oRd       = fields.rd;
    assign oFunct3   = fields.funct3;
    assign oFunct7   = fields.funct7;
    assign oOpcode   = fields.opcode;

    // State, PC, IR and timeout counter registers.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state   <= IDLE;
            pc      <= PC_RESET;
            ir      <= '0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            ir      <= ir_nxt;
            tmo_cnt <= tmo_cnt_nxt;
        end
    end

    // Next-state, datapath updates and next values of the registered strobes.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ir_nxt      = ir;
        tmo_cnt_nxt = tmo_cnt;
        illegal_nxt = 1'b0;
        timeout_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (iEn) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                // Data is only accepted while the request is actually presented.
                if (oImemReq && iImemValid) begin
                    ir_nxt    = iImemData;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                case (fields.opcode)
                    OP_R, OP_I: begin
                        tmo_cnt_nxt = '0;
                        state_nxt   = EXEC;
                    end
                    OP_SYS: begin
                        state_nxt = HALT;
                    end
                    default: begin
                        illegal_nxt = 1'b1;
                        pc_nxt      = pc + PC_STEP;
                        state_nxt   = iEn ? FETCH : IDLE;
                    end
                endcase
            end
            EXEC: begin
                if (iAluDone) begin
                    state_nxt = WB;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout_nxt = 1'b1;
                    pc_nxt      = pc + PC_STEP;
                    state_nxt   = iEn ? FETCH : IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            WB: begin
                pc_nxt    = pc + PC_STEP;
                state_nxt = iEn ? FETCH : IDLE;
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // The fetch request waits one cycle behind an error pulse so no two strobes overlap.
        imem_req_nxt  = (state_nxt == FETCH) && !illegal_nxt && !timeout_nxt;
        rf_rd_en_nxt  = (state_nxt == DECODE);
        alu_start_nxt = (state_nxt == EXEC) && (state != EXEC);
        rf_we_nxt     = (state_nxt == WB) && (fields.rd != '0);
        halt_nxt      = (state_nxt == HALT);
    end

    // Registered output strobes.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oImemReq  <= 1'b0;
            oRfRdEn   <= 1'b0;
            oAluStart <= 1'b0;
            oRfWe     <= 1'b0;
            oIllegal  <= 1'b0;
            oTimeout  <= 1'b0;
            oHalt     <= 1'b0;
        end else begin
            oImemReq  <= imem_req_nxt;
            oRfRdEn   <= rf_rd_en_nxt;
            oAluStart <= alu_start_nxt;
            oRfWe     <= rf_we_nxt;
            oIllegal  <= illegal_nxt;
            oTimeout  <= timeout_nxt;
            oHalt     <= halt_nxt;
        end
    end

`ifdef SEQ_INSTR_CNT_EN
    // Retired-instruction count: one per WB cycle, wraps naturally.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oInstrCnt <= '0;
        end else if (state == WB) begin
            oInstrCnt <= oInstrCnt + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: table of single-instruction vectors plus
// hand sequences for iEn=0 after an illegal op, PC wrap, halt and mid-EXEC reset.
module tb_core_seq_ctrl;

    logic        iClk;
    logic        iRst;
    logic        iEn;
    logic        iImemValid;
    logic [31:0] iImemData;
    logic        iAluDone;

    logic        oImemReq,  w_ImemReq;
    logic [31:0] oImemAddr, w_ImemAddr;
    logic [4:0]  oRs1, oRs2, oRd, w_Rs1, w_Rs2, w_Rd;
    logic [2:0]  oFunct3, w_Funct3;
    logic [6:0]  oFunct7, oOpcode, w_Funct7, w_Opcode;
    logic        oRfRdEn, oAluStart, oRfWe, oIllegal, oTimeout, oHalt;
    logic        w_RfRdEn, w_AluStart, w_RfWe, w_Illegal, w_Timeout, w_Halt;
`ifdef SEQ_INSTR_CNT_EN
    logic [31:0] oInstrCnt, w_InstrCnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] model_pc;

    typedef struct {
        logic [31:0] instr;
        int          vdly;
        int          ddly;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [6:0]  op;
        int          n_start;
        int          n_we;
        int          n_ill;
        int          n_tmo;
    } vec_t;

    vec_t vecs[5];

    core_seq_ctrl u_dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iEn        (iEn),
        .oImemReq   (oImemReq),
        .oImemAddr  (oImemAddr),
        .iImemValid (iImemValid),
        .iImemData  (iImemData),
        .oRs1       (oRs1),
        .oRs2       (oRs2),
        .oRd        (oRd),
        .oFunct3    (oFunct3),
        .oFunct7    (oFunct7),
        .oOpcode    (oOpcode),
        .oRfRdEn    (oRfRdEn),
        .oAluStart  (oAluStart),
        .iAluDone   (iAluDone),
        .oRfWe      (oRfWe),
        .oIllegal   (oIllegal),
        .oTimeout   (oTimeout),
        .oHalt      (oHalt)
`ifdef SEQ_INSTR_CNT_EN
        ,
        .oInstrCnt  (oInstrCnt)
`endif
    );

    core_seq_ctrl #(.PC_RESET(32'hFFFF_FFFC)) u_wrap (
        .iClk       (iClk),
        .iRst       (iRst),
        .iEn        (iEn),
        .oImemReq   (w_ImemReq),
        .oImemAddr  (w_ImemAddr),
        .iImemValid (iImemValid),
        .iImemData  (iImemData),
        .oRs1       (w_Rs1),
        .oRs2       (w_Rs2),
        .oRd        (w_Rd),
        .oFunct3    (w_Funct3),
        .oFunct7    (w_Funct7),
        .oOpcode    (w_Opcode),
        .oRfRdEn    (w_RfRdEn),
        .oAluStart  (w_AluStart),
        .iAluDone   (iAluDone),
        .oRfWe      (w_RfWe),
        .oIllegal   (w_Illegal),
        .oTimeout   (w_Timeout),
        .oHalt      (w_Halt)
`ifdef SEQ_INSTR_CNT_EN
        ,
        .oInstrCnt  (w_InstrCnt)
`endif
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic wait_req();
        for (int k = 0; k < 50 && !oImemReq; k++) tick();
        check("fetch_req", 32'(oImemReq), 32'd1);
    endtask

    // Strobes other than a lone fetch request must never overlap.
    always @(negedge iClk) begin
        if (!iRst) begin
            checks++;
            if ($countones({oImemReq, oRfRdEn, oAluStart, oRfWe, oIllegal, oTimeout}) > 1) begin
                errors++;
                $display("FAIL strobe_overlap: got %b expected at most one high at %0t",
                         {oImemReq, oRfRdEn, oAluStart, oRfWe, oIllegal, oTimeout}, $time);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int s, n_start, n_we, n_ill, n_tmo, tmo_at;
        s = -1; n_start = 0; n_we = 0; n_ill = 0; n_tmo = 0; tmo_at = -1;
        wait_req();
        check("fetch_addr", oImemAddr, model_pc);
        repeat (v.vdly) tick();
        iImemData  = v.instr;
        iImemValid = 1'b1;
        tick();
        iImemValid = 1'b0;
        iImemData  = 32'h0;
        check("rf_rd_en", 32'(oRfRdEn), 32'd1);
        check("rs1", 32'(oRs1), 32'(v.rs1));
        check("rs2", 32'(oRs2), 32'(v.rs2));
        check("rd", 32'(oRd), 32'(v.rd));
        check("funct3", 32'(oFunct3), 32'(v.f3));
        check("funct7", 32'(oFunct7), 32'(v.f7));
        check("opcode", 32'(oOpcode), 32'(v.op));
        for (int c = 0; c < 400; c++) begin
            if (oAluStart) begin
                n_start++;
                if (s < 0) s = c;
            end
            if (oRfWe) n_we++;
            if (oIllegal) n_ill++;
            if (oTimeout) begin
                n_tmo++;
                tmo_at = c - s;
            end
            if (oImemReq) break;
            iAluDone = (s >= 0) && (v.ddly >= 0) && (c - s == v.ddly);
            tick();
        end
        iAluDone = 1'b0;
        check("next_fetch_req", 32'(oImemReq), 32'd1);
        model_pc = model_pc + 32'd4;
        check("next_fetch_addr", oImemAddr, model_pc);
        check("n_alu_start", 32'(n_start), 32'(v.n_start));
        check("n_rf_we", 32'(n_we), 32'(v.n_we));
        check("n_illegal", 32'(n_ill), 32'(v.n_ill));
        check("n_timeout", 32'(n_tmo), 32'(v.n_tmo));
        if (v.n_tmo != 0) check("timeout_latency", 32'(tmo_at), 32'd255);
    endtask

    initial begin
        vecs[0] = '{32'h002081B3, 2,  3, 5'd1,  5'd2,  5'd3,  3'd0, 7'h00, 7'h33, 1, 1, 0, 0};
        vecs[1] = '{32'h00000013, 0,  0, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 7'h13, 1, 0, 0, 0};
        vecs[2] = '{32'hFFFFFFFF, 1, -1, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 7'h7F, 0, 0, 1, 0};
        vecs[3] = '{32'h00130293, 1,  1, 5'd6,  5'd1,  5'd5,  3'd0, 7'h00, 7'h13, 1, 1, 0, 0};
        vecs[4] = '{32'h40208233, 0, -1, 5'd1,  5'd2,  5'd4,  3'd0, 7'h20, 7'h33, 1, 0, 0, 1};

        iRst = 1'b1; iEn = 1'b0; iImemValid = 1'b0; iImemData = 32'h0; iAluDone = 1'b0;
        model_pc = 32'h0;
        repeat (3) tick();
        check("rst_imem_req", 32'(oImemReq), 32'd0);
        check("rst_imem_addr", oImemAddr, 32'h0);
        check("rst_wrap_addr", w_ImemAddr, 32'hFFFF_FFFC);
        check("rst_strobes", 32'({oRfRdEn, oAluStart, oRfWe, oIllegal, oTimeout, oHalt}), 32'd0);
        check("rst_fields", 32'({oRs1, oRs2, oRd, oOpcode}), 32'd0);

        iRst = 1'b0;
        repeat (3) begin
            tick();
            check("idle_hold", 32'(oImemReq), 32'd0);
        end
        iEn = 1'b1;
        tick();
        check("idle_to_fetch", 32'(oImemReq), 32'd1);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
            if (i == 0) check("pc_wrap", w_ImemAddr, 32'h0);
        end

        // Illegal op decoded with iEn low parks in IDLE.
        wait_req();
        iImemData = 32'hFFFFFFFF; iImemValid = 1'b1;
        tick();
        iImemValid = 1'b0; iEn = 1'b0;
        tick();
        check("ill_idle_pulse", 32'(oIllegal), 32'd1);
        check("ill_idle_req", 32'(oImemReq), 32'd0);
        model_pc = model_pc + 32'd4;
        repeat (3) begin
            tick();
            check("ill_idle_hold", 32'(oImemReq | oIllegal), 32'd0);
        end
        check("ill_idle_pc", oImemAddr, model_pc);
        iEn = 1'b1;
        tick();
        check("ill_idle_resume", 32'(oImemReq), 32'd1);

        // Halt is sticky even with iEn high.
        iImemData = 32'h00000073; iImemValid = 1'b1;
        tick();
        iImemValid = 1'b0;
        tick();
        check("halt_set", 32'(oHalt), 32'd1);
        repeat (8) begin
            tick();
            check("halt_sticky", 32'({oHalt, oImemReq, oRfRdEn, oAluStart, oRfWe, oIllegal, oTimeout}),
                  32'b1000000);
        end
        check("halt_no_pc", oImemAddr, model_pc);
        iRst = 1'b1;
        #1;
        check("halt_rst_clear", 32'(oHalt), 32'd0);
        check("halt_rst_addr", oImemAddr, 32'h0);
        tick();
        iRst = 1'b0;
        model_pc = 32'h0;

        // Reset asserted mid-EXEC abandons the instruction.
        wait_req();
        iImemData = 32'h00208233; iImemValid = 1'b1;
        tick();
        iImemValid = 1'b0;
        tick();
        check("mid_exec_start", 32'(oAluStart), 32'd1);
        repeat (2) tick();
        #3 iRst = 1'b1;
        #1;
        check("mid_rst_strobes",
              32'({oImemReq, oRfRdEn, oAluStart, oRfWe, oIllegal, oTimeout, oHalt}), 32'd0);
        check("mid_rst_addr", oImemAddr, 32'h0);
        check("mid_rst_rd", 32'(oRd), 32'd0);
        repeat (2) begin
            tick();
            check("mid_rst_quiet", 32'({oRfWe, oTimeout, oIllegal}), 32'd0);
        end
`ifdef SEQ_INSTR_CNT_EN
        check("instr_cnt_rst", oInstrCnt, 32'd0);
`endif
        iRst = 1'b0;
        run_vec(vecs[0]);
        run_vec(vecs[1]);
        run_vec(vecs[3]);
`ifdef SEQ_INSTR_CNT_EN
        check("instr_cnt_3", oInstrCnt, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
